// File: rtl/core_sequencer.sv
// ============================================================================
// core_sequencer : multi-cycle control FSM for the single-issue RV32I core
// Revision       : 1.0
// ============================================================================
`default_nettype none

module core_sequencer #(
  parameter int TIMEOUT = 255,
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               mem_req,
  output logic               mem_ifetch,
  output logic               mem_we,
  input  logic               mem_ready,
  input  logic               mem_err,
  output logic               ir_we,
  output logic               ld_we,
  input  logic               dec_mem,
  input  logic               dec_mem_read,
  input  logic               dec_branch,
  input  logic               dec_unconditional_branch,
  input  logic [1:0]         dec_wb,
  input  logic               cmp_taken,
  output logic               pc_we,
  output logic               pc_sel,
  output logic               rf_we,
  input  logic               halt_req,
  output logic               halted,
  output logic               fault,
  output logic               retire,
  output logic [COUNT_W-1:0] instret
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALTED = 3'd6;
  localparam logic [2:0] S_FAULT  = 3'd7;

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [TO_W-1:0] wait_cnt;
  logic            port_busy;
  logic            resp_ok;
  logic            timed_out;

  assign port_busy = (state == S_FETCH) || (state == S_MEM);
  // Error dominates a simultaneous ready.
  assign resp_ok   = mem_ready & ~mem_err;
  assign timed_out = (TIMEOUT != 0) && (wait_cnt == TO_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RESET;
    end else begin
      state <= state_nxt;
    end
  end

  // Counter is held at zero outside FETCH/MEM, so entry always starts from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (port_busy && !mem_ready && !mem_err) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (state == S_WB) begin
      instret <= instret + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET:  state_nxt = S_FETCH;
      S_FETCH: begin
        if (mem_err)        state_nxt = S_FAULT;
        else if (resp_ok)   state_nxt = S_DECODE;
        else if (timed_out) state_nxt = S_FAULT;
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = dec_mem ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_err)        state_nxt = S_FAULT;
        else if (resp_ok)   state_nxt = S_WB;
        else if (timed_out) state_nxt = S_FAULT;
      end
      S_WB:     state_nxt = halt_req ? S_HALTED : S_FETCH;
      S_HALTED: state_nxt = halt_req ? S_HALTED : S_FETCH;
      S_FAULT:  state_nxt = S_FAULT;
      default:  state_nxt = S_FAULT;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_ifetch = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    ld_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 1'b0;
    rf_we      = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;
    retire     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        mem_ifetch = 1'b1;
        ir_we      = resp_ok;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = ~dec_mem_read;
        ld_we   = resp_ok & dec_mem_read;
      end
      S_WB: begin
        rf_we  = (dec_wb != 2'd0);
        pc_we  = 1'b1;
        pc_sel = dec_branch & (dec_unconditional_branch | cmp_taken);
        retire = 1'b1;
      end
      S_HALTED: halted = 1'b1;
      S_FAULT:  fault  = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire
